// File: rtl/board_access_if.sv
// Shared board access bundle between the four requesters, the clear control
// and the board arbiter.
interface board_access_if #(
  parameter int CELL_W = 2
);
  logic              game_req;
  logic              game_we;
  logic [2:0]        game_row;
  logic [2:0]        game_col;
  logic [CELL_W-1:0] game_wdata;
  logic              game_gnt;
  logic              game_rvalid;
  logic              vga_req;
  logic [2:0]        vga_row;
  logic [2:0]        vga_col;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic              scan_req;
  logic [2:0]        scan_row;
  logic [2:0]        scan_col;
  logic              scan_gnt;
  logic              scan_rvalid;
  logic              dbg_en;
  logic              dbg_req;
  logic [2:0]        dbg_row;
  logic [2:0]        dbg_col;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;
  logic [CELL_W-1:0] rdata;
  logic              addr_err;

  modport master (
    output game_req, game_we, game_row, game_col, game_wdata,
    output vga_req, vga_row, vga_col,
    output scan_req, scan_row, scan_col,
    output dbg_en, dbg_req, dbg_row, dbg_col, clear_start,
    input  game_gnt, game_rvalid, vga_gnt, vga_rvalid, scan_gnt, scan_rvalid,
    input  dbg_gnt, dbg_rvalid, clear_busy, clear_done, rdata, addr_err
  );

  modport slave (
    input  game_req, game_we, game_row, game_col, game_wdata,
    input  vga_req, vga_row, vga_col,
    input  scan_req, scan_row, scan_col,
    input  dbg_en, dbg_req, dbg_row, dbg_col, clear_start,
    output game_gnt, game_rvalid, vga_gnt, vga_rvalid, scan_gnt, scan_rvalid,
    output dbg_gnt, dbg_rvalid, clear_busy, clear_done, rdata, addr_err
  );
endinterface

// File: rtl/board_access_arbiter.sv
// Connect-four board store with a single access port shared by game, vga,
// scan and debug requesters, plus a one-cell-per-cycle clear sweep.
module board_access_arbiter #(
  parameter int ROWS     = 6,
  parameter int COLS     = 7,
  parameter int CELL_W   = 2,
  parameter int MAX_WAIT = 8
) (
  input logic          clk,
  input logic          rst,
  board_access_if.slave bus
);
  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = $clog2(CELLS);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [CNT_W-1:0]  dbg_cnt_q, dbg_cnt_d;
  logic [CELL_W-1:0] board_q [CELLS];
  logic [CELL_W-1:0] board_d [CELLS];
  logic [3:0]        rvalid_q, rvalid_d;
  logic [CELL_W-1:0] rdata_q, rdata_d;
  logic              addr_err_q, addr_err_d;
  logic              clear_busy_q, clear_busy_d;
  logic              clear_done_q, clear_done_d;

  logic [3:0]        gnt_s;
  logic              dbg_req_s, scan_prom_s, dbg_prom_s;
  logic [2:0]        sel_row_s, sel_col_s;
  logic              sel_we_s, sel_oor_s;
  logic [IDX_W-1:0]  sel_idx_s;

  // Grant order: game, then promoted scan/dbg, then vga, then scan/dbg round-robin (rr_q=1 favours dbg).
  always_comb begin
    dbg_req_s   = bus.dbg_en & bus.dbg_req;
    scan_prom_s = bus.scan_req & (scan_cnt_q == CNT_W'(MAX_WAIT));
    dbg_prom_s  = dbg_req_s & (dbg_cnt_q == CNT_W'(MAX_WAIT));
    gnt_s       = 4'b0000;
    if (rst || (state_q != ST_IDLE)) begin
      gnt_s = 4'b0000;
    end else if (bus.game_req) begin
      gnt_s = 4'b0001;
    end else if (scan_prom_s && dbg_prom_s) begin
      gnt_s = rr_q ? 4'b1000 : 4'b0100;
    end else if (scan_prom_s) begin
      gnt_s = 4'b0100;
    end else if (dbg_prom_s) begin
      gnt_s = 4'b1000;
    end else if (bus.vga_req) begin
      gnt_s = 4'b0010;
    end else if (bus.scan_req && dbg_req_s) begin
      gnt_s = rr_q ? 4'b1000 : 4'b0100;
    end else if (bus.scan_req) begin
      gnt_s = 4'b0100;
    end else if (dbg_req_s) begin
      gnt_s = 4'b1000;
    end else begin
      gnt_s = 4'b0000;
    end
  end

  always_comb begin
    if (gnt_s[0]) begin
      sel_row_s = bus.game_row;
      sel_col_s = bus.game_col;
    end else if (gnt_s[1]) begin
      sel_row_s = bus.vga_row;
      sel_col_s = bus.vga_col;
    end else if (gnt_s[2]) begin
      sel_row_s = bus.scan_row;
      sel_col_s = bus.scan_col;
    end else begin
      sel_row_s = bus.dbg_row;
      sel_col_s = bus.dbg_col;
    end
    sel_we_s  = gnt_s[0] & bus.game_we;
    sel_oor_s = (sel_row_s >= 3'(ROWS)) || (sel_col_s >= 3'(COLS));
    sel_idx_s = IDX_W'(sel_row_s) * IDX_W'(COLS) + IDX_W'(sel_col_s);
  end

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    rr_d         = rr_q;
    scan_cnt_d   = scan_cnt_q;
    dbg_cnt_d    = dbg_cnt_q;
    board_d      = board_q;
    rvalid_d     = 4'b0000;
    rdata_d      = rdata_q;
    addr_err_d   = 1'b0;
    clear_busy_d = clear_busy_q;
    clear_done_d = 1'b0;

    // Out-of-range accesses are granted but drop writes and read back zero.
    if (|gnt_s) begin
      addr_err_d = sel_oor_s;
      if (sel_we_s) begin
        if (!sel_oor_s) begin
          board_d[sel_idx_s] = bus.game_wdata;
        end else begin
          board_d = board_q;
        end
      end else begin
        rvalid_d = gnt_s;
        rdata_d  = sel_oor_s ? {CELL_W{1'b0}} : board_q[sel_idx_s];
      end
    end else begin
      addr_err_d = 1'b0;
    end

    if (gnt_s[2] || gnt_s[3]) begin
      rr_d = ~rr_q;
    end else begin
      rr_d = rr_q;
    end

    if (gnt_s[2]) begin
      scan_cnt_d = {CNT_W{1'b0}};
    end else if (bus.scan_req && (scan_cnt_q != CNT_W'(MAX_WAIT))) begin
      scan_cnt_d = scan_cnt_q + CNT_W'(1);
    end else begin
      scan_cnt_d = scan_cnt_q;
    end

    if (!bus.dbg_en || gnt_s[3]) begin
      dbg_cnt_d = {CNT_W{1'b0}};
    end else if (bus.dbg_req && (dbg_cnt_q != CNT_W'(MAX_WAIT))) begin
      dbg_cnt_d = dbg_cnt_q + CNT_W'(1);
    end else begin
      dbg_cnt_d = dbg_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.clear_start) begin
          state_d      = ST_CLEAR;
          clr_idx_d    = {IDX_W{1'b0}};
          clear_busy_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        board_d[clr_idx_q] = {CELL_W{1'b0}};
        if (clr_idx_q == IDX_W'(CELLS - 1)) begin
          state_d      = ST_IDLE;
          clear_busy_d = 1'b0;
          clear_done_d = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d      = ST_IDLE;
        clear_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      clr_idx_q    <= {IDX_W{1'b0}};
      rr_q         <= 1'b0;
      scan_cnt_q   <= {CNT_W{1'b0}};
      dbg_cnt_q    <= {CNT_W{1'b0}};
      rvalid_q     <= 4'b0000;
      rdata_q      <= {CELL_W{1'b0}};
      addr_err_q   <= 1'b0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      for (int i = 0; i < CELLS; i++) begin
        board_q[i] <= {CELL_W{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      rr_q         <= rr_d;
      scan_cnt_q   <= scan_cnt_d;
      dbg_cnt_q    <= dbg_cnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      addr_err_q   <= addr_err_d;
      clear_busy_q <= clear_busy_d;
      clear_done_q <= clear_done_d;
      for (int i = 0; i < CELLS; i++) begin
        board_q[i] <= board_d[i];
      end
    end
  end

  assign bus.game_gnt    = gnt_s[0];
  assign bus.vga_gnt     = gnt_s[1];
  assign bus.scan_gnt    = gnt_s[2];
  assign bus.dbg_gnt     = gnt_s[3];
  assign bus.game_rvalid = rvalid_q[0];
  assign bus.vga_rvalid  = rvalid_q[1];
  assign bus.scan_rvalid = rvalid_q[2];
  assign bus.dbg_rvalid  = rvalid_q[3];
  assign bus.rdata       = rdata_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.clear_busy  = clear_busy_q;
  assign bus.clear_done  = clear_done_q;
endmodule
